// File: rtl/booth_mul_sched.sv
// Sequential radix-2 Booth multiplier shared by two requesters via round-robin.
// Optional BOOTH_ZERO_BYPASS_EN: zero operand skips the iteration phase.
module booth_mul_sched #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_x,
  input  logic [WIDTH-1:0]     req0_y,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_x,
  input  logic [WIDTH-1:0]     req1_y,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_id,
  output logic [2*WIDTH-1:0]   res_z
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             e1_q, e1_d;
  logic [CW-1:0]    count_q, count_d;
  logic             id_q, id_d;
  logic             last_q, last_d;

  logic             grant;
  logic             idle_open;
  logic             accept;
  logic [WIDTH-1:0] sel_x, sel_y;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   sum;

  // On a tie the requester that did not win last time gets the datapath.
  always_comb begin
    grant     = req1_valid & (~req0_valid | ~last_q);
    idle_open = (state_q == IDLE) && !rst;
    accept    = idle_open && (grant ? req1_valid : req0_valid);
    sel_x     = grant ? req1_x : req0_x;
    sel_y     = grant ? req1_y : req0_y;
  end

  assign req0_ready = idle_open && !grant;
  assign req1_ready = idle_open && grant;
  assign res_valid  = (state_q == DONE);
  assign res_id     = id_q;
  assign res_z      = {a_q[WIDTH-1:0], q_q};

  // A carries one extra sign bit so subtracting the most-negative M stays exact.
  always_comb begin
    m_ext = {m_q[WIDTH-1], m_q};
    case ({q_q[0], e1_q})
      2'b10:   sum = a_q - m_ext;
      2'b01:   sum = a_q + m_ext;
      default: sum = a_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    e1_d    = e1_q;
    count_d = count_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          q_d     = sel_x;
          m_d     = sel_y;
          a_d     = '0;
          e1_d    = 1'b0;
          count_d = '0;
          id_d    = grant;
          last_d  = grant;
          state_d = ITER;
`ifdef BOOTH_ZERO_BYPASS_EN
          if ((sel_x == '0) || (sel_y == '0)) begin
            q_d     = '0;
            state_d = DONE;
          end
`endif
        end
      end
      ITER: begin
        a_d     = {sum[WIDTH], sum[WIDTH:1]};
        q_d     = {sum[0], q_q[WIDTH-1:1]};
        e1_d    = q_q[0];
        count_d = count_q + CNT_ONE;
        if (count_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      e1_q    <= 1'b0;
      count_q <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      e1_q    <= e1_d;
      count_q <= count_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed self-checking bench for booth_mul_sched (WIDTH = 8).
module tb_booth_mul_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [7:0]  req0_x, req0_y;
  logic        req1_valid, req1_ready;
  logic [7:0]  req1_x, req1_y;
  logic        res_valid, res_ready, res_id;
  logic [15:0] res_z;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef BOOTH_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = 8;
`endif

  booth_mul_sched #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_z(res_z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair on a port, confirm it is granted, and let the accept edge pass.
  task automatic issue(input string tag, input int port, input logic [7:0] x, input logic [7:0] y);
    if (port == 0) begin
      req0_valid = 1'b1; req0_x = x; req0_y = y;
    end else begin
      req1_valid = 1'b1; req1_x = x; req1_y = y;
    end
    #1;
    chk({tag, "_rdy"}, 32'(port == 0 ? req0_ready : req1_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, input int exp_lat, input logic [15:0] exp_z,
                          input logic exp_id);
    int n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_z"}, 32'(res_z), 32'(exp_z));
    chk({tag, "_id"}, 32'(res_id), 32'(exp_id));
  endtask

  task automatic take(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_drop"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b1; req0_x = 8'd2; req0_y = 8'd3;
    req1_valid = 1'b1; req1_x = 8'd4; req1_y = 8'd5;
    tick(); tick();
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
    chk("rst_vld", 32'(res_valid), 32'd0);
    chk("rst_z", 32'(res_z), 32'd0);
    chk("rst_id", 32'(res_id), 32'd0);

    // Both requesters pending from reset: 0 wins first, then 1.
    rst = 1'b0;
    #1;
    chk("tie0_rdy0", 32'(req0_ready), 32'd1);
    chk("tie0_rdy1", 32'(req1_ready), 32'd0);
    tick();
    wait_res("tie0", 8, 16'd6, 1'b0);
    chk("tie0_done_rdy1", 32'(req1_ready), 32'd0);
    take("tie0");
    chk("tie1_rdy1", 32'(req1_ready), 32'd1);
    chk("tie1_rdy0", 32'(req0_ready), 32'd0);
    tick();
    wait_res("tie1", 8, 16'd20, 1'b1);
    take("tie1");
    chk("tie2_rdy0", 32'(req0_ready), 32'd1);
    tick();
    wait_res("tie2", 8, 16'd6, 1'b0);
    take("tie2");
    chk("tie3_rdy1", 32'(req1_ready), 32'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_res("tie3", 8, 16'd20, 1'b1);
    take("tie3");

    // Signed corner products.
    issue("p7m3", 0, 8'd7, 8'hFD);
    wait_res("p7m3", 8, 16'hFFEB, 1'b0);
    take("p7m3");
    issue("mnmn", 1, 8'h80, 8'h80);
    wait_res("mnmn", 8, 16'h4000, 1'b1);
    take("mnmn");
    issue("mxmn", 1, 8'h7F, 8'h80);
    wait_res("mxmn", 8, 16'hC080, 1'b1);
    take("mxmn");
    issue("m1m1", 1, 8'hFF, 8'hFF);
    wait_res("m1m1", 8, 16'h0001, 1'b1);
    take("m1m1");

    // Consumer stall in DONE with another request pending.
    issue("hold", 0, 8'd5, 8'hFA);
    wait_res("hold", 8, 16'hFFE2, 1'b0);
    req0_valid = 1'b1; req0_x = 8'd1; req0_y = 8'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_vld", 32'(res_valid), 32'd1);
      chk("hold_z", 32'(res_z), 32'hFFE2);
      chk("hold_id", 32'(res_id), 32'd0);
      chk("hold_rdy0", 32'(req0_ready), 32'd0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("hold_idle_vld", 32'(res_valid), 32'd0);
    chk("hold_idle_rdy0", 32'(req0_ready), 32'd1);
    req0_valid = 1'b0;

    // Reset mid-iteration aborts the product.
    issue("abort", 1, 8'd100, 8'd100);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_vld", 32'(res_valid), 32'd0);
    chk("abort_z", 32'(res_z), 32'd0);
    issue("p6x7", 0, 8'd6, 8'd7);
    wait_res("p6x7", 8, 16'd42, 1'b0);
    take("p6x7");

    // Zero operand: short path only when the bypass is built in.
    issue("zero", 1, 8'd0, 8'hB3);
    wait_res("zero", ZERO_LAT, 16'd0, 1'b1);
    take("zero");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
